// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
// Default geometry, stage record layout and stage-count helper.
package cla_pkg;

  localparam int CLA_WIDTH = 16;
  localparam int CLA_BLK   = 4;

  typedef struct packed {
    logic                 valid;
    logic [CLA_WIDTH-1:0] psum;
    logic [CLA_WIDTH-1:0] a;
    logic [CLA_WIDTH-1:0] b;
    logic                 carry;
  } cla_stage_t;

  function automatic int cla_nstage(input int width, input int blk);
    return width / blk;
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLK-bit carry-lookahead block.
// CLA_OVF_EN adds cmsb, the carry into the block MSB.
module cla_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co
`ifdef CLA_OVF_EN
  ,
  output logic           cmsb
`endif
);

  logic [BLK-1:0] g;
  logic [BLK-1:0] p;
  logic [BLK:0]   c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < BLK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    s  = p ^ c[BLK-1:0];
    co = c[BLK];
  end

`ifdef CLA_OVF_EN
  assign cmsb = c[BLK-1];
`endif

endmodule

// File: rtl/pipelined_cla_adder.sv
// Streaming adder: one BLK-bit lookahead block resolved per stage.
// Define CLA_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int BLK   = CLA_BLK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid,
  input  logic             out_ready
`ifdef CLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSTAGE = cla_nstage(WIDTH, BLK);

  generate
    if ((WIDTH % BLK) != 0) begin : g_bad_geom
      $error("pipelined_cla_adder: WIDTH must be a multiple of BLK");
    end
  endgenerate

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry;
  } stage_t;

  stage_t stg_q [NSTAGE];
  stage_t stg_d [NSTAGE];

  logic [BLK-1:0] blk_s  [NSTAGE];
  logic           blk_co [NSTAGE];

  logic             advance;
  logic [WIDTH-1:0] fin_sum;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

`ifdef CLA_OVF_EN
  logic blk_cm [NSTAGE];
  logic ovf_q, ovf_d;
`endif

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    cla_block #(.BLK(BLK)) u_blk (
      .a    (stg_q[k].a[k*BLK +: BLK]),
      .b    (stg_q[k].b[k*BLK +: BLK]),
      .ci   (stg_q[k].carry),
      .s    (blk_s[k]),
      .co   (blk_co[k])
`ifdef CLA_OVF_EN
      ,
      .cmsb (blk_cm[k])
`endif
    );
  end

  // Global stall: the whole pipe moves only when the output slot frees up.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      stg_d[k] = stg_q[k];
    end
    fin_sum = stg_q[NSTAGE-1].psum;
    fin_sum[(NSTAGE-1)*BLK +: BLK] = blk_s[NSTAGE-1];
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
`ifdef CLA_OVF_EN
    ovf_d       = ovf_q;
`endif
    if (advance) begin
      stg_d[0].valid = in_valid;
      stg_d[0].psum  = '0;
      stg_d[0].a     = A;
      stg_d[0].b     = B;
      stg_d[0].carry = cin;
      for (int k = 1; k < NSTAGE; k++) begin
        stg_d[k] = stg_q[k-1];
        stg_d[k].psum[(k-1)*BLK +: BLK] = blk_s[k-1];
        stg_d[k].carry = blk_co[k-1];
      end
      out_valid_d = stg_q[NSTAGE-1].valid;
      if (stg_q[NSTAGE-1].valid) begin
        sum_d   = fin_sum;
        carry_d = blk_co[NSTAGE-1];
`ifdef CLA_OVF_EN
        ovf_d   = blk_cm[NSTAGE-1] ^ blk_co[NSTAGE-1];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTAGE; k++) begin
        stg_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
`ifdef CLA_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      stg_q       <= stg_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
`ifdef CLA_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry     = carry_q;
`ifdef CLA_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Randomized and directed bench for pipelined_cla_adder (16/4).
// Reference: slot array of precomputed A+B+cin results.
module tb_pipelined_cla_adder;

  localparam int W = 16;
  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] A, B;
  logic         cin;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] sum;
  logic         carry;
  logic         out_valid;
  logic         out_ready;
`ifdef CLA_OVF_EN
  logic         ovf;
`endif

  pipelined_cla_adder #(.WIDTH(W), .BLK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .carry     (carry),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef CLA_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: each in-flight add is a slot holding its final answer.
  bit          mv [N];
  logic [W:0]  mr [N];
  bit          mf [N];
  bit          mo_v;
  logic [W:0]  mo_r;
  bit          mo_f;

  function automatic bit sovf(input logic [W-1:0] a, b,
                              input logic [W:0] r);
    return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
  endfunction

  task automatic step(input bit r, input bit iv,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input bit ordy);
    bit adv;
    rst = r; in_valid = iv; A = a; B = b; cin = c;
    out_ready = ordy;
    #1;
    adv = !mo_v || ordy;
    chk("in_ready", {31'd0, in_ready}, {31'd0, adv});
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < N; i++) mv[i] = 0;
      mo_v = 0; mo_r = '0; mo_f = 0;
    end else if (adv) begin
      mo_v = mv[N-1];
      if (mv[N-1]) begin
        mo_r = mr[N-1];
        mo_f = mf[N-1];
      end
      for (int i = N - 1; i > 0; i--) begin
        mv[i] = mv[i-1]; mr[i] = mr[i-1]; mf[i] = mf[i-1];
      end
      mv[0] = iv;
      mr[0] = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      mf[0] = sovf(a, b, mr[0]);
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, mo_v});
    if (mo_v) begin
      chk("sum", {16'd0, sum}, {16'd0, mo_r[W-1:0]});
      chk("carry", {31'd0, carry}, {31'd0, mo_r[W]});
`ifdef CLA_OVF_EN
      chk("ovf", {31'd0, ovf}, {31'd0, mo_f});
`endif
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 1);
  endtask

  initial begin
    rst = 1; in_valid = 0; A = '0; B = '0; cin = 0; out_ready = 1;
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; mr[i] = '0; mf[i] = 0;
    end
    mo_v = 0; mo_r = '0; mo_f = 0;

    step(1, 0, '0, '0, 0, 0);
    step(1, 0, '0, '0, 0, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_carry", {31'd0, carry}, 32'd0);
    idle(1);

    step(0, 1, 16'h1234, 16'h4321, 0, 1);
    idle(3);
    chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
    idle(1);
    chk("lat4_valid", {31'd0, out_valid}, 32'd1);
    chk("sum_5555", {16'd0, sum}, 32'h5555);
    step(0, 1, 16'hFFFF, 16'h0001, 0, 1);
    idle(N + 1);

    for (int i = 0; i < 8; i++) begin
      if (i == 3) step(0, 1, 16'hA5A5, 16'h5A5A, 1, 1);
      else step(0, 1, W'($urandom), W'($urandom), 1'($urandom), 1);
    end
    idle(N + 1);

    for (int i = 0; i < 6; i++)
      step(0, 1, W'($urandom), W'($urandom), 1'($urandom), 1);
    for (int i = 0; i < 3; i++)
      step(0, 1, W'($urandom), W'($urandom), 1'($urandom), 0);
    idle(N + 2);

    idle(N);
    for (int i = 0; i < 3; i++)
      step(0, 1, W'($urandom), W'($urandom), 1'($urandom), 1);
    step(1, 0, '0, '0, 0, 1);
    idle(N + 2);

    step(0, 1, 16'h7FFF, 16'h0001, 0, 1);
    step(0, 1, 16'h8000, 16'h8000, 0, 1);
    step(0, 1, 16'h8000, 16'hFFFF, 0, 1);
    idle(N + 1);

    for (int i = 0; i < 400; i++)
      step(0, $urandom_range(0, 3) != 0, W'($urandom), W'($urandom),
           1'($urandom), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 200; i++)
      step(0, 1, W'($urandom), W'($urandom), 1'($urandom),
           $urandom_range(0, 1) != 0);
    idle(N + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
